// File: rtl/dnn_argmax_fix3_pkg.sv
// Shared types and sizing for the fix3 argmax classification stage.
// Scores are 3-bit signed fixed-point, so the scan starts from the most negative code.
package dnn_fix3_pkg;

   localparam int DATA_WIDTH  = 3;
   localparam int NUM_CLASSES = 10;
   localparam int IDX_WIDTH   = 4;

   typedef logic signed [DATA_WIDTH-1:0] score_t;
   typedef logic        [IDX_WIDTH-1:0]  class_t;

   typedef enum logic [1:0] {
      ARG_IDLE   = 2'd0,
      ARG_SCAN   = 2'd1,
      ARG_DRAIN  = 2'd2,
      ARG_REPORT = 2'd3
   } argmax_state_e;

   localparam score_t SCORE_MIN = score_t'({1'b1, {(DATA_WIDTH-1){1'b0}}});
   localparam class_t LAST_IDX  = class_t'(NUM_CLASSES - 1);

endpackage

// File: rtl/dnn_argmax_fix3_if.sv
// Signal bundle between the argmax stage (slave) and its environment (master).
interface dnn_argmax_fix3_if #(
   parameter int CNT_WIDTH = 16
);
   import dnn_fix3_pkg::*;

   // dnn_done is a level: only a rise seen while idle starts a scan. out_idx/out_data is a
   // combinational select with no handshake. result_valid is a one-cycle strobe, no backpressure.
   logic                 dnn_done;
   class_t               label;
   logic                 clear;
   class_t               out_idx;
   score_t               out_data;
   logic                 busy;
   logic                 result_valid;
   class_t               result_class;
   score_t               result_max;
   logic                 correct;
   logic [CNT_WIDTH-1:0] hit_count;
   logic [CNT_WIDTH-1:0] total_count;
   argmax_state_e        dbg_state;

   modport master (
      output dnn_done, label, clear, out_data,
      input  out_idx, busy, result_valid, result_class, result_max, correct,
             hit_count, total_count, dbg_state
   );

   modport slave (
      input  dnn_done, label, clear, out_data,
      output out_idx, busy, result_valid, result_class, result_max, correct,
             hit_count, total_count, dbg_state
   );

endinterface

// File: rtl/dnn_argmax_fix3_rise_detect.sv
// Rising-edge detector. The register resets to 1 so a level already high when reset
// releases is not mistaken for a fresh edge.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_in,
   output logic o_rise
);

   logic r_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q <= 1'b1;
      end else begin
         r_q <= i_in;
      end
   end

   assign o_rise = i_in & ~r_q;

endmodule

// File: rtl/dnn_argmax_fix3.sv
// Argmax stage behind the fix3 inference top: scans the class scores after each dnn_done
// rise, registers winner, score and label match, and keeps saturating hit/total counters.
module dnn_argmax_fix3
   import dnn_fix3_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   dnn_argmax_fix3_if.slave bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SCAN   = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_REPORT = 2'd3;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [1:0]           r_state;
   logic [1:0]           w_state_nxt;
   class_t               r_k;
   class_t               r_label;
   score_t               r_samp;
   class_t               r_samp_idx;
   logic                 r_samp_vld;
   score_t               r_run_max;
   class_t               r_run_cls;
   class_t               r_res_cls;
   score_t               r_res_max;
   logic                 r_correct;
   logic [CNT_WIDTH-1:0] r_hit;
   logic [CNT_WIDTH-1:0] r_total;

   logic w_rise;
   logic w_trigger;
   logic w_scan_last;
   logic w_cmp_en;
   logic w_take;
   logic w_report;
   logic w_correct_now;

   rise_detect u_rise (
      .clk    (clk),
      .rst    (rst),
      .i_in   (bus.dnn_done),
      .o_rise (w_rise)
   );

   assign w_trigger     = (r_state == S_IDLE) && w_rise;
   assign w_scan_last   = (r_state == S_SCAN) && (r_k == LAST_IDX);
   assign w_report      = (r_state == S_REPORT);
   assign w_correct_now = (r_run_cls == r_label);

   // Sample register lags out_idx by one cycle; strict > keeps the earliest index on ties.
   assign w_cmp_en = r_samp_vld && ((r_state == S_SCAN) || (r_state == S_DRAIN));
   assign w_take   = w_cmp_en && (r_samp > r_run_max);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_rise) w_state_nxt = S_SCAN;
         S_SCAN:   if (w_scan_last) w_state_nxt = S_DRAIN;
         S_DRAIN:  w_state_nxt = S_REPORT;
         S_REPORT: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_k        <= '0;
         r_label    <= '0;
         r_samp     <= '0;
         r_samp_idx <= '0;
         r_samp_vld <= 1'b0;
         r_run_max  <= SCORE_MIN;
         r_run_cls  <= '0;
      end else if (w_trigger) begin
         r_k        <= '0;
         r_label    <= bus.label;
         r_samp_vld <= 1'b0;
         r_run_max  <= SCORE_MIN;
         r_run_cls  <= '0;
      end else begin
         if (r_state == S_SCAN) begin
            r_samp     <= bus.out_data;
            r_samp_idx <= r_k;
            r_samp_vld <= 1'b1;
            if (!w_scan_last) begin
               r_k <= r_k + 1'b1;
            end
         end
         if (w_take) begin
            r_run_max <= r_samp;
            r_run_cls <= r_samp_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_res_cls <= '0;
         r_res_max <= '0;
         r_correct <= 1'b0;
      end else if (w_report) begin
         r_res_cls <= r_run_cls;
         r_res_max <= r_run_max;
         r_correct <= w_correct_now;
      end
   end

   // clear has priority over a coincident REPORT increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hit   <= '0;
         r_total <= '0;
      end else if (bus.clear) begin
         r_hit   <= '0;
         r_total <= '0;
      end else if (w_report) begin
         if (r_total != CNT_MAX) begin
            r_total <= r_total + 1'b1;
         end
         if (w_correct_now && (r_hit != CNT_MAX)) begin
            r_hit <= r_hit + 1'b1;
         end
      end
   end

   assign bus.out_idx      = (r_state == S_SCAN) ? r_k : '0;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.result_valid = w_report;
   assign bus.result_class = r_res_cls;
   assign bus.result_max   = r_res_max;
   assign bus.correct      = r_correct;
   assign bus.hit_count    = r_hit;
   assign bus.total_count  = r_total;
   assign bus.dbg_state    = argmax_state_e'(r_state);

endmodule

// File: tb/tb_dnn_argmax_fix3.sv
// Directed bench for dnn_argmax_fix3: a score table answers out_idx, expected results are
// queued at each trigger and compared when the result registers; a 3-bit-counter twin shows saturation.
module tb_dnn_argmax_fix3;
   import dnn_fix3_pkg::*;

   logic clk;
   logic rst;

   dnn_argmax_fix3_if #(.CNT_WIDTH(16)) bus ();
   dnn_argmax_fix3_if #(.CNT_WIDTH(3))  bus_s ();

   dnn_argmax_fix3 #(.CNT_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   dnn_argmax_fix3 #(.CNT_WIDTH(3)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- score table (inference top model) ----------------
   score_t scores [16];
   int     tv [10];

   assign bus.out_data     = scores[bus.out_idx];
   assign bus_s.out_data   = scores[bus_s.out_idx];
   assign bus_s.dnn_done   = bus.dnn_done;
   assign bus_s.label      = bus.label;
   assign bus_s.clear      = bus.clear;

   // ---------------- bookkeeping ----------------
   int n_chk = 0;
   int n_bad = 0;

   logic [7:0]  exp_q[$];
   logic [15:0] m_hit   = '0;
   logic [15:0] m_total = '0;
   logic [2:0]  s_hit   = '0;
   logic [2:0]  s_total = '0;
   int          rd_idx  = 0;

   // ---------------- output monitor ----------------
   logic        pend      = 1'b0;
   int          valid_cnt = 0;
   int          obs_cnt   = 0;
   logic [45:0] obs_mem [64];

   always @(negedge clk) begin
      if (!rst) begin
         pend <= 1'b0;
      end else begin
         pend <= bus.result_valid;
         if (bus.result_valid) valid_cnt <= valid_cnt + 1;
         if (pend && obs_cnt < 64) begin
            obs_mem[obs_cnt[5:0]] <= {bus_s.total_count, bus_s.hit_count, bus.total_count,
                                      bus.hit_count, bus.correct, bus.result_max, bus.result_class};
            obs_cnt <= obs_cnt + 1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_tv();
      for (int i = 0; i < 10; i++) scores[i] = score_t'(tv[i]);
   endtask

   function automatic logic [7:0] expect_of(input logic [3:0] lbl);
      score_t     best;
      logic [3:0] bi;
      best = score_t'(-4);
      bi   = 4'd0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
         if (scores[i] > best) begin
            best = scores[i];
            bi   = 4'(i);
         end
      end
      return {(bi == lbl), best, bi};
   endfunction

   // Call right after a negedge: the rise is sampled at the following posedge (cycle T).
   task automatic start_scan(input logic [3:0] lbl);
      bus.label    = lbl;
      bus.dnn_done = 1'b1;
      exp_q.push_back(expect_of(lbl));
   endtask

   task automatic collect(input string tag, input bit cleared);
      logic [45:0] o;
      logic [7:0]  e;
      int          n;
      n = 0;
      while (obs_cnt == rd_idx && n < 60) begin
         @(posedge clk);
         n++;
      end
      chk({tag, "_seen"}, 32'(obs_cnt != rd_idx), 32'd1);
      if (obs_cnt != rd_idx) begin
         o = obs_mem[rd_idx[5:0]];
         rd_idx++;
         chk({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
         e = 8'h00;
         if (exp_q.size() != 0) e = exp_q.pop_front();
         if (cleared) begin
            m_hit = '0; m_total = '0; s_hit = '0; s_total = '0;
         end else begin
            if (m_total != 16'hFFFF) m_total++;
            if (e[7] && m_hit != 16'hFFFF) m_hit++;
            if (s_total != 3'h7) s_total++;
            if (e[7] && s_hit != 3'h7) s_hit++;
         end
         chk({tag, "_class"},   32'(o[3:0]),   32'(e[3:0]));
         chk({tag, "_max"},     32'(o[6:4]),   32'(e[6:4]));
         chk({tag, "_correct"}, 32'(o[7]),     32'(e[7]));
         chk({tag, "_hit"},     32'(o[23:8]),  32'(m_hit));
         chk({tag, "_total"},   32'(o[39:24]), 32'(m_total));
         chk({tag, "_s_hit"},   32'(o[42:40]), 32'(s_hit));
         chk({tag, "_s_total"}, 32'(o[45:43]), 32'(s_total));
      end
   endtask

   task automatic run_pulse(input string tag, input logic [3:0] lbl);
      @(negedge clk);
      start_scan(lbl);
      @(negedge clk);
      bus.dnn_done = 1'b0;
      collect(tag, 1'b0);
   endtask

   task automatic scan_timed(input string tag, input logic [3:0] lbl);
      @(negedge clk);
      start_scan(lbl);
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (c == 1) bus.dnn_done = 1'b0;
         chk({tag, "_idx"},   32'(bus.out_idx),      (c <= 10) ? c - 1 : 0);
         chk({tag, "_busy"},  32'(bus.busy),         32'(c <= 12));
         chk({tag, "_valid"}, 32'(bus.result_valid), 32'(c == 12));
      end
      collect(tag, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_idx"},   32'(bus.out_idx),                 32'd0);
      chk({tag, "_busy"},  32'(bus.busy),                    32'd0);
      chk({tag, "_valid"}, 32'(bus.result_valid),            32'd0);
      chk({tag, "_class"}, 32'(bus.result_class),            32'd0);
      chk({tag, "_max"},   32'($unsigned(bus.result_max)),   32'd0);
      chk({tag, "_corr"},  32'(bus.correct),                 32'd0);
      chk({tag, "_hit"},   32'(bus.hit_count),               32'd0);
      chk({tag, "_total"}, 32'(bus.total_count),             32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int         v0;
      logic [7:0] e;
      logic [3:0] lbl;

      rst          = 1'b0;
      bus.dnn_done = 1'b0;
      bus.label    = '0;
      bus.clear    = 1'b0;
      for (int i = 0; i < 16; i++) scores[i] = '0;

      // Reset values, then release with dnn_done already high: no scan may start.
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      bus.dnn_done = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("hi_at_release_busy",  32'(bus.busy), 32'd0);
      chk("hi_at_release_valid", valid_cnt,     32'd0);
      bus.dnn_done = 1'b0;
      @(negedge clk);

      // Basic scan with cycle-accurate out_idx/busy/result_valid.
      tv = '{0, 1, -2, 3, 2, 0, -1, 1, 0, -4};
      apply_tv();
      scan_timed("basic", 4'd3);

      // All scores at the minimum: class 0 wins, label mismatch.
      tv = '{-4, -4, -4, -4, -4, -4, -4, -4, -4, -4};
      apply_tv();
      run_pulse("allmin", 4'd5);

      // Tie at indices 4 and 7: lower index wins.
      tv = '{0, 1, -1, 0, 2, 1, 0, 2, -3, 1};
      apply_tv();
      scan_timed("tie", 4'd4);

      // Labels beyond the class range never match.
      tv = '{-4, -4, -4, -4, -4, -4, -4, -4, -4, -4};
      apply_tv();
      run_pulse("lbl10", 4'd10);
      tv = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
      apply_tv();
      run_pulse("lbl15", 4'd15);

      // dnn_done held high ~30 cycles with a second rise mid-scan: exactly one result.
      tv = '{-3, -2, -1, 0, 1, 2, 3, -4, -4, -4};
      apply_tv();
      v0 = valid_cnt;
      for (int c = 0; c < 36; c++) begin
         @(negedge clk);
         if (c == 0) start_scan(4'd6);
         else bus.dnn_done = (c == 4 || c >= 30) ? 1'b0 : 1'b1;
         if (c >= 1 && c <= 10) chk("held_idx", 32'(bus.out_idx), c - 1);
      end
      chk("held_one_valid", valid_cnt - v0, 32'd1);
      collect("held", 1'b0);

      // Reset pulsed mid-scan (T+6) while dnn_done stays high.
      tv = '{1, 0, 2, -1, 0, 0, 1, 0, 0, 0};
      apply_tv();
      v0 = valid_cnt;
      @(negedge clk);
      bus.label    = 4'd2;
      bus.dnn_done = 1'b1;
      repeat (6) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midrst");
      m_hit = '0; m_total = '0; s_hit = '0; s_total = '0;
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (20) @(negedge clk);
      chk("midrst_no_valid", valid_cnt - v0, 32'd0);
      chk("midrst_no_retrig", 32'(bus.busy), 32'd0);
      bus.dnn_done = 1'b0;
      @(negedge clk);
      run_pulse("fresh", 4'd2);

      // Random scans with mostly matching labels: 3-bit twin saturates both counters.
      for (int i = 0; i < 9; i++) begin
         for (int j = 0; j < 10; j++) tv[j] = int'($urandom_range(0, 7)) - 4;
         apply_tv();
         e   = expect_of(4'd0);
         lbl = (i == 3) ? 4'd15 : e[3:0];
         run_pulse("rand", lbl);
      end
      chk("sat_s_total", 32'(bus_s.total_count), 32'd7);
      chk("sat_s_hit",   32'(bus_s.hit_count),   32'd7);
      chk("sat_total",   32'(bus.total_count),   32'd10);
      chk("sat_hit",     32'(bus.hit_count),     32'd9);

      // clear coincident with REPORT: clear wins.
      tv = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 0};
      apply_tv();
      @(negedge clk);
      start_scan(4'd8);
      @(negedge clk);
      bus.dnn_done = 1'b0;
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1 bus.clear = 1'b1;
      chk("clr_report_valid", 32'(bus.result_valid), 32'd1);
      @(posedge clk);
      #1 bus.clear = 1'b0;
      chk("clr_report_hit",   32'(bus.hit_count),   32'd0);
      chk("clr_report_total", 32'(bus.total_count), 32'd0);
      collect("clr", 1'b1);

      // Counting resumes after clear; then a plain clear while idle.
      run_pulse("after_clr", 4'd8);
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("idle_clr_hit",   32'(bus.hit_count),   32'd0);
      chk("idle_clr_total", 32'(bus.total_count), 32'd0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/dnn_argmax_fix3.md
# dnn_argmax_fix3

Classification stage directly downstream of the 3-bit fixed-point sigmoid inference top. After inference completes, it scans the ten class outputs through the top's output-index mux and registers the winning digit and its score. It also compares the winner against a supplied ground-truth label and keeps saturating hit/total counters, so an accuracy figure can be read without host post-processing.

## Interface
- DATA_WIDTH, 3, width of the signed class scores.
- NUM_CLASSES, 10, number of scores scanned; index range 0..NUM_CLASSES-1.
- IDX_WIDTH, 4, width of the class index and label.
- CNT_WIDTH, 16, width of the hit and total counters.

Ports:
- clk  in  1  single clock; all state rises on posedge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- dnn_done  in  1  done level from the inference top; a rising edge triggers one scan.
- label  in  IDX_WIDTH  ground-truth digit; sampled on the trigger cycle.
- clear  in  1  synchronous clear of both counters.
- out_idx  out  IDX_WIDTH  class select driven to the inference top.
- out_data  in  DATA_WIDTH (signed)  score returned for out_idx.
- busy  out  1  high from the cycle after the trigger through the REPORT cycle.
- result_valid  out  1  one-cycle pulse when a new result is registered.
- result_class  out  IDX_WIDTH  argmax index; held until the next REPORT.
- result_max  out  DATA_WIDTH (signed)  winning score; held.
- correct  out  1  result_class == captured label; held.
- hit_count  out  CNT_WIDTH  number of correct results, saturating.
- total_count  out  CNT_WIDTH  number of results, saturating.

## Operation
- States: IDLE, SCAN, DRAIN, REPORT.
- IDLE:
  - out_idx = 0.
  - Trigger = dnn_done high AND done_q low, where done_q is dnn_done registered.
  - On trigger: capture label, set scan counter k = 0, load running max = -4 (most negative value) and running class = 0, go to SCAN.
- SCAN:
  - out_idx = k; k increments each cycle.
  - out_data is sampled at each clock edge into a sample register tagged with that cycle's k.
  - Every cycle after the first, the previously sampled score is compared against the running max and the running max/class update if needed.
  - After the cycle with k = NUM_CLASSES-1, go to DRAIN.
- DRAIN: perform the final compare for index NUM_CLASSES-1, then go to REPORT.
- REPORT (one cycle):
  - result_valid = 1.
  - result_class, result_max and correct load from the running values.
  - total_count increments; hit_count increments if correct. Both saturate at all-ones.
  - Then go to IDLE.
- Compare rule:
  - Signed, strictly greater.
  - On ties the lowest index wins; all scores -4 gives class 0.
- A label value above NUM_CLASSES-1 never produces correct = 1.
- A dnn_done rising edge while not in IDLE is ignored. done_q still tracks dnn_done, so a level that stays high afterwards does not retrigger.
- clear zeroes both counters on the next edge. If clear and REPORT occur in the same cycle, clear wins and no increment is applied.
- Reset values:
  - state = IDLE, out_idx = 0, busy = 0, result_valid = 0.
  - result_class = 0, result_max = 0, correct = 0, counters = 0.
  - done_q = 1, so a dnn_done already high when reset releases does not trigger a scan.
- Reset asserted mid-scan: returns to IDLE immediately; no result_valid and no counter update occur.

## Timing
- Cycle T: trigger seen.
- T+1..T+NUM_CLASSES: out_idx = 0..9 (SCAN).
- T+11: DRAIN.
- T+12: REPORT, result_valid high.
- The first new trigger can be accepted at T+13.
- out_data must be valid by the clock edge that ends the cycle in which out_idx is driven. Combinational select paths in the inference top meet this requirement.
- busy is high T+1..T+12.
- Result outputs and counters change only on the edge that ends REPORT, or on clear.

## Structure
- Package dnn_fix3_pkg contains:
  - DATA_WIDTH, NUM_CLASSES, IDX_WIDTH localparams;
  - typedef score_t (signed DATA_WIDTH);
  - typedef class_t (IDX_WIDTH);
  - argmax state enum argmax_state_e.
- One sub-module, rise_detect:
  - registers its input with a reset value of 1;
  - outputs in & ~q.
- The FSM, scan counter, compare datapath and counters stay in dnn_argmax_fix3.

## Test plan
- Scores {0,1,-2,3,2,0,-1,1,0,-4}, label 3, single dnn_done pulse -> result_valid at T+12, result_class 3, result_max 3, correct 1, hit/total 1/1.
- All scores -4, label 5 -> result_class 0, result_max -4, correct 0, total increments, hit unchanged.
- Tie: score 2 at indices 4 and 7, all others lower -> result_class 4.
- dnn_done held high for 30 cycles, plus a second rise at T+5 -> exactly one result_valid; out_idx sequence 0..9 checked cycle by cycle.
- rst pulsed low at T+6 -> no result_valid, outputs at reset values. Then dnn_done low, then high again -> fresh scan completes normally.
- Counters preloaded by 65535 scans (or forced) -> total saturates at 65535. clear coincident with REPORT -> both counters 0 next cycle.
